// File: rtl/ps2_pkg.sv
// Shared scan-code constants, FSM state encoding and key event layout
// for the PS/2 key scheduler.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ACK     = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_evt_t;

  // Keyboard status/response bytes carry no key information.
  function automatic logic is_status(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous event FIFO; head entry is presented directly from the storage
// flops and forced to zero while empty.
module ps2_evt_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic [9:0],
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  T              din_i,
  input  logic          pop_i,
  output T              dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = empty_o ? T'('0) : mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= T'('0);
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_scheduler.sv
// Handshakes with the PS/2 byte receiver, merges E0/F0 prefixes into one
// event per key, queues events for the CPU and tracks the flap key level.
//
//  state   | meaning
//  IDLE    | waiting for synced rx_valid rising edge
//  CAPTURE | sample rx_data, decode, push event
//  ACK     | hold rx_ack for ACK_CYCLES cycles
//  WAIT_LO | wait for rx_valid to drop, bounded by TIMEOUT_CYC
module ps2_key_scheduler
  import ps2_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 8,
  parameter int         ACK_CYCLES  = 4,
  parameter int         TIMEOUT_CYC = 50000,
  parameter logic [7:0] KEY_CODE    = 8'h29,
  localparam int        CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_ack,
  input  logic             evt_pop,
  output logic             evt_valid,
  output logic [9:0]       evt_data,
  output logic [CNT_W-1:0] evt_count,
  output logic             overflow,
  output logic             timeout_err,
  input  logic             err_clr,
  output logic             key_held
);

  localparam int TMR_MAX = (TIMEOUT_CYC > ACK_CYCLES) ? TIMEOUT_CYC : ACK_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] ACK_LOAD = TMR_W'(ACK_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LOAD  = TMR_W'(TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [2:0]       vld_sync_q;
  logic [7:0]       byte_q, byte_d;
  logic             ext_pend_q, ext_pend_d;
  logic             brk_pend_q, brk_pend_d;
  logic             key_held_q, key_held_d;
  logic             overflow_q, overflow_d;
  logic             timeout_q, timeout_d;
  logic             ack_q, ack_d;

  logic             vld_s, vld_rise;
  logic             push, to_set, drop;
  key_evt_t         push_evt, head_evt;
  logic             fifo_full, fifo_empty;

  // Bits 0/1 form the synchronizer; bit 2 is the previous synced value for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_sync_q <= '0;
    else        vld_sync_q <= {vld_sync_q[1:0], rx_valid};
  end

  assign vld_s    = vld_sync_q[1];
  assign vld_rise = vld_sync_q[1] & ~vld_sync_q[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      byte_q     <= '0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      key_held_q <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      byte_q     <= byte_d;
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
      key_held_q <= key_held_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      ack_q      <= ack_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    byte_d     = byte_q;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    key_held_d = key_held_q;
    push       = 1'b0;
    to_set     = 1'b0;
    push_evt   = '{ext: ext_pend_q, brk: brk_pend_q, code: rx_data};

    case (state_q)
      IDLE: begin
        if (vld_rise) state_d = CAPTURE;
      end
      CAPTURE: begin
        byte_d = rx_data;
        if (rx_data == SC_EXT) begin
          ext_pend_d = 1'b1;
        end else if (rx_data == SC_BRK) begin
          brk_pend_d = 1'b1;
        end else if (rx_data == SC_PAUSE) begin
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
        end else if (!is_status(rx_data)) begin
          push       = 1'b1;
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
          // Tracked regardless of whether the FIFO has room for the event.
          if (!ext_pend_q && rx_data == KEY_CODE) key_held_d = ~brk_pend_q;
        end
        tmr_d   = ACK_LOAD;
        state_d = ACK;
      end
      ACK: begin
        if (tmr_q == '0) begin
          tmr_d   = TO_LOAD;
          state_d = WAIT_LO;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      WAIT_LO: begin
        if (!vld_s) begin
          state_d = IDLE;
        end else if (tmr_q == '0) begin
          to_set     = 1'b1;
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
          state_d    = IDLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A push into a full FIFO survives only if the head is popped in the same cycle.
  assign drop = push & fifo_full & ~evt_pop;

  always_comb begin
    overflow_d = overflow_q;
    timeout_d  = timeout_q;
    if (err_clr) begin
      overflow_d = 1'b0;
      timeout_d  = 1'b0;
    end
    if (drop)   overflow_d = 1'b1;
    if (to_set) timeout_d  = 1'b1;
  end

  // Registered so the receiver's async-set input never sees decode glitches.
  assign ack_d = (state_d == ACK);

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (key_evt_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (push_evt),
    .pop_i   (evt_pop),
    .dout_o  (head_evt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (evt_count)
  );

  assign rx_ack      = ack_q;
  assign evt_valid   = ~fifo_empty;
  assign evt_data    = head_evt;
  assign overflow    = overflow_q;
  assign timeout_err = timeout_q;
  assign key_held    = key_held_q;

endmodule

// File: tb/tb_ps2_key_scheduler.sv
// Scoreboard bench: stimulus queues expected events, a monitor pops and
// compares each event the scheduler presents.
module tb_ps2_key_scheduler;

  localparam int DEPTH = 8;
  localparam int ACKC  = 4;
  localparam int TO    = 5000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       evt_pop = 1'b0;
  logic       err_clr = 1'b0;
  logic       rx_ack, evt_valid, overflow, timeout_err, key_held;
  logic [9:0] evt_data;
  logic [3:0] evt_count;

  int         ncmp = 0;
  int         nfail = 0;
  logic [9:0] exp_q[$];
  bit         mon_en = 1'b0;
  int         pop_req_cnt = 0;
  int         pop_done_cnt = 0;

  ps2_key_scheduler #(
    .FIFO_DEPTH  (DEPTH),
    .ACK_CYCLES  (ACKC),
    .TIMEOUT_CYC (TO),
    .KEY_CODE    (8'h29)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ack      (rx_ack),
    .evt_pop     (evt_pop),
    .evt_valid   (evt_valid),
    .evt_data    (evt_data),
    .evt_count   (evt_count),
    .overflow    (overflow),
    .timeout_err (timeout_err),
    .err_clr     (err_clr),
    .key_held    (key_held)
  );

  always #10 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rx_ack"},    rx_ack, 0);
    chk({tag, "_evt_valid"}, evt_valid, 0);
    chk({tag, "_evt_data"},  evt_data, 0);
    chk({tag, "_evt_count"}, evt_count, 0);
    chk({tag, "_overflow"},  overflow, 0);
    chk({tag, "_timeout"},   timeout_err, 0);
    chk({tag, "_key_held"},  key_held, 0);
  endtask

  // Receiver model: raise rx_valid with data, expect one ACKC-wide ack pulse,
  // then optionally drop rx_valid after `hold` extra cycles.
  task automatic send_byte(input logic [7:0] b, input int hold, input bit drop);
    int n;
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ack && n < 20) begin @(negedge clk); n++; end
    chk("ack_seen", rx_ack, 1);
    n = 0;
    while (rx_ack && n < 20) begin @(negedge clk); n++; end
    chk("ack_width", n, ACKC);
    if (drop) begin
      cyc(hold);
      rx_valid = 1'b0;
      cyc(5);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("drain", exp_q.size(), 0);
    cyc(2);
  endtask

  // Monitor: pops whenever enabled (or on an explicit one-shot request)
  // and compares the head against the scoreboard.
  initial begin
    logic [9:0] exp;
    forever begin
      @(negedge clk);
      #1;
      evt_pop = 1'b0;
      if (evt_valid && (mon_en || pop_req_cnt != pop_done_cnt)) begin
        if (pop_req_cnt != pop_done_cnt) pop_done_cnt++;
        ncmp++;
        if (exp_q.size() == 0) begin
          nfail++;
          $display("FAIL unexpected_evt: got %0h expected none", evt_data);
        end else begin
          exp = exp_q.pop_front();
          if (evt_data !== exp) begin
            nfail++;
            $display("FAIL evt_data: got %0h expected %0h", evt_data, exp);
          end
        end
        evt_pop = 1'b1;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    cyc(3);
    chk_quiet("reset");
    rst_n = 1'b1;
    cyc(2);

    // Long-held make code, checked directly before the monitor drains it.
    mon_en = 1'b0;
    send_byte(8'h1C, 4000, 1'b1);
    chk("make_valid", evt_valid, 1);
    chk("make_data", evt_data, 10'h01C);
    chk("make_count", evt_count, 1);
    exp_q.push_back(10'h01C);
    mon_en = 1'b1;
    drain();

    exp_q.push_back(10'h375);
    send_byte(8'hE0, 0, 1'b1);
    send_byte(8'hF0, 0, 1'b1);
    send_byte(8'h75, 0, 1'b1);
    drain();
    chk("ext_brk_keyheld", key_held, 0);

    exp_q.push_back(10'h029);
    send_byte(8'h29, 0, 1'b1);
    drain();
    chk("space_make_held", key_held, 1);
    exp_q.push_back(10'h129);
    send_byte(8'hF0, 0, 1'b1);
    send_byte(8'h29, 0, 1'b1);
    drain();
    chk("space_break_held", key_held, 0);

    exp_q.push_back(10'h01C);
    send_byte(8'hAA, 0, 1'b1);
    send_byte(8'h1C, 0, 1'b1);
    drain();

    exp_q.push_back(10'h275);
    send_byte(8'hE0, 0, 1'b1);
    send_byte(8'hE0, 0, 1'b1);
    send_byte(8'h75, 0, 1'b1);
    exp_q.push_back(10'h01D);
    send_byte(8'hE0, 0, 1'b1);
    send_byte(8'hE1, 0, 1'b1);
    send_byte(8'h1D, 0, 1'b1);
    drain();

    // Overflow: DEPTH+1 makes with nobody popping.
    mon_en = 1'b0;
    cyc(2);
    for (int i = 0; i <= DEPTH; i++) begin
      send_byte(8'h10 + 8'(i), 0, 1'b1);
      if (i < DEPTH) exp_q.push_back(10'h010 + 10'(i));
    end
    chk("ovf_count", evt_count, DEPTH);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head", evt_data, 10'h010);

    // Push and pop in the same cycle: pop lands on the CAPTURE cycle.
    exp_q.push_back(10'h01B);
    rx_data  = 8'h1B;
    rx_valid = 1'b1;
    cyc(3);
    pop_req_cnt++;
    cyc(1);
    chk("pushpop_count", evt_count, DEPTH);
    chk("pushpop_ovf_sticky", overflow, 1);
    n = 0;
    while (!rx_ack && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (rx_ack && n < 20) begin @(negedge clk); n++; end
    rx_valid = 1'b0;
    cyc(5);

    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    chk("ovf_cleared", overflow, 0);
    mon_en = 1'b1;
    drain();

    // rx_valid stuck high after a byte.
    exp_q.push_back(10'h022);
    send_byte(8'h22, 0, 1'b0);
    n = 0;
    while (!timeout_err && n < TO + 100) begin @(negedge clk); n++; end
    chk("timeout_set", timeout_err, 1);
    chk("timeout_delay", (n >= TO - 10 && n <= TO + 10), 1);
    drain();
    cyc(10);
    chk("timeout_no_retrigger_ack", rx_ack, 0);
    chk("timeout_no_retrigger_cnt", evt_count, 0);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    chk("timeout_cleared", timeout_err, 0);
    rx_valid = 1'b0;
    cyc(5);

    // Reset while waiting for rx_valid to fall.
    exp_q.push_back(10'h029);
    send_byte(8'h29, 0, 1'b1);
    drain();
    exp_q.push_back(10'h023);
    send_byte(8'h23, 0, 1'b0);
    drain();
    chk("pre_reset_held", key_held, 1);
    cyc(3);
    rst_n = 1'b0;
    cyc(1);
    rx_valid = 1'b0;
    cyc(1);
    chk_quiet("midreset");
    rst_n = 1'b1;
    cyc(3);
    chk_quiet("postreset");

    exp_q.push_back(10'h01C);
    send_byte(8'h1C, 0, 1'b1);
    drain();
    chk("final_count", evt_count, 0);

    cyc(5);
    chk("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
